// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: multi-beat loads and stores over the
// data-cache req/resp bus, with valid/ready handshakes on both pipeline sides.
module mem_stage_lsu #(
    parameter int BUS_W  = 64,
    parameter int DATA_W = 64,
    parameter int TAG_W  = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_load,
    input  logic              in_is_store,
    input  logic [63:0]       in_ld_addr,
    input  logic [63:0]       in_st_addr,
    input  logic [DATA_W-1:0] in_st_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_ld_data,
    output logic              reqcyc,
    output logic [BUS_W-1:0]  req,
    output logic [TAG_W-1:0]  reqtag,
    input  logic              reqack,
    input  logic [BUS_W-1:0]  resp,
    input  logic              respcyc,
    output logic              respack
);

    localparam int BEATS  = DATA_W / BUS_W;
    localparam int CNT_W  = $clog2(BEATS) + 1;
    localparam int ADDR_W = (BUS_W > 64) ? BUS_W : 64;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_ADDR = 3'd1;
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] WR_ADDR = 3'd3;
    localparam logic [2:0] WR_DATA = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    localparam logic [TAG_W-1:0] TAG_RD = TAG_W'(3'b011) << (TAG_W - 3);
    localparam logic [TAG_W-1:0] TAG_WR = TAG_W'(3'b111) << (TAG_W - 3);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(BEATS - 1);

    logic [2:0]        state;
    logic [CNT_W-1:0]  beatCnt;
    logic              pendStore;
    logic [63:0]       stAddr;
    logic [DATA_W-1:0] stData;
    logic              lastBeat;

    assign in_ready = (state == IDLE);
    assign lastBeat = (beatCnt == LAST);

    // Addresses are truncated or zero-extended to the bus width.
    function automatic logic [BUS_W-1:0] addrBeat(input logic [63:0] a);
        logic [ADDR_W-1:0] w;
        w = ADDR_W'(a);
        return w[BUS_W-1:0];
    endfunction

    // Beat 0 is the most significant slice of the operand.
    function automatic logic [BUS_W-1:0] dataBeat(
        input logic [DATA_W-1:0] d,
        input logic [CNT_W-1:0]  idx
    );
        logic [BUS_W-1:0] r;
        r = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (idx == CNT_W'(k)) r = d[DATA_W-1-k*BUS_W -: BUS_W];
        end
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] insertBeat(
        input logic [DATA_W-1:0] d,
        input logic [CNT_W-1:0]  idx,
        input logic [BUS_W-1:0]  b
    );
        logic [DATA_W-1:0] r;
        r = d;
        for (int k = 0; k < BEATS; k++) begin
            if (idx == CNT_W'(k)) r[DATA_W-1-k*BUS_W -: BUS_W] = b;
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            beatCnt     <= '0;
            pendStore   <= 1'b0;
            stAddr      <= '0;
            stData      <= '0;
            reqcyc      <= 1'b0;
            req         <= '0;
            reqtag      <= '0;
            respack     <= 1'b0;
            out_valid   <= 1'b0;
            out_ld_data <= '0;
        end else begin
            respack <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        pendStore   <= in_is_store;
                        stAddr      <= in_st_addr;
                        stData      <= in_st_data;
                        out_ld_data <= '0;
                        beatCnt     <= '0;
                        if (in_is_load) begin
                            state  <= RD_ADDR;
                            reqcyc <= 1'b1;
                            req    <= addrBeat(in_ld_addr);
                            reqtag <= TAG_RD;
                        end else if (in_is_store) begin
                            state  <= WR_ADDR;
                            reqcyc <= 1'b1;
                            req    <= addrBeat(in_st_addr);
                            reqtag <= TAG_WR;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                RD_ADDR: begin
                    if (reqack) begin
                        state   <= RD_DATA;
                        beatCnt <= '0;
                        reqcyc  <= 1'b0;
                        req     <= '0;
                        reqtag  <= '0;
                    end
                end
                RD_DATA: begin
                    if (respcyc) begin
                        respack     <= 1'b1;
                        out_ld_data <= insertBeat(out_ld_data, beatCnt, resp);
                        beatCnt     <= beatCnt + 1'b1;
                        if (lastBeat) begin
                            beatCnt <= '0;
                            if (pendStore) begin
                                state  <= WR_ADDR;
                                reqcyc <= 1'b1;
                                req    <= addrBeat(stAddr);
                                reqtag <= TAG_WR;
                            end else begin
                                state     <= DONE;
                                out_valid <= 1'b1;
                            end
                        end
                    end
                end
                WR_ADDR: begin
                    if (reqack) begin
                        state   <= WR_DATA;
                        beatCnt <= '0;
                        req     <= dataBeat(stData, '0);
                    end
                end
                WR_DATA: begin
                    if (reqack) begin
                        if (lastBeat) begin
                            state     <= DONE;
                            beatCnt   <= '0;
                            reqcyc    <= 1'b0;
                            req       <= '0;
                            reqtag    <= '0;
                            out_valid <= 1'b1;
                        end else begin
                            beatCnt <= beatCnt + 1'b1;
                            req     <= dataBeat(stData, beatCnt + 1'b1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
